// File: rtl/ide_seq.sv
// ide_seq: sequencer for the address-transfer (INC/DEC/ENT/ENN) command class.
// Accepts a command in IDLE, optionally reads the target register, drives the
// external datapath, latches its result and writes the target register back.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, c, f, m       command request, opcode, field, effective address
//   busy, done, illegal  status: not idle, completion pulse, rejected command
//   overflow_set         pulse to set the machine overflow toggle
//   reg_sel              target register (0 A, 1..6 I1..I6, 7 X)
//   reg_rd_en/reg_rdata  register read strobe / data (valid one cycle later)
//   reg_wr_en/reg_wdata  register write strobe / data
//   ide_in/ide_m/ide_field  operands to the datapath
//   ide_out/ide_overflow    combinational datapath result
module ide_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  c,
  input  logic [5:0]  f,
  input  logic [12:0] m,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic        overflow_set,
  output logic [2:0]  reg_sel,
  output logic        reg_rd_en,
  input  logic [30:0] reg_rdata,
  output logic        reg_wr_en,
  output logic [30:0] reg_wdata,
  output logic [30:0] ide_in,
  output logic [12:0] ide_m,
  output logic [1:0]  ide_field,
  input  logic [30:0] ide_out,
  input  logic        ide_overflow
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRead  = 3'd1;
  localparam logic [2:0] StExec  = 3'd2;
  localparam logic [2:0] StWrite = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [2:0]  sel_q, sel_d;
  logic [1:0]  field_q, field_d;
  logic [12:0] m_q, m_d;
  logic [30:0] result_q, result_d;
  logic        ovf_q, ovf_d;
  logic        illegal_q, illegal_d;

  logic        legal;
  logic [5:0]  c_off;
  logic        is_index;

  assign c_off    = c - 6'd48;
  assign legal    = (c >= 6'd48) && (c <= 6'd55) && (f <= 6'd3);
  // I1..I6 are short registers: only sign and 12 magnitude bits are kept.
  assign is_index = (sel_q != 3'd0) && (sel_q != 3'd7);

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    field_d   = field_q;
    m_d       = m_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    illegal_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (legal) begin
            sel_d   = c_off[2:0];
            field_d = f[1:0];
            m_d     = m;
            // ENT/ENN need no register operand, so the read is skipped.
            state_d = f[1] ? StExec : StRead;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      StRead:  state_d = StExec;
      StExec: begin
        result_d = ide_out;
        ovf_d    = ide_overflow;
        state_d  = StWrite;
      end
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sel_q     <= 3'd0;
      field_q   <= 2'd0;
      m_q       <= 13'd0;
      result_q  <= 31'd0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      field_q   <= field_d;
      m_q       <= m_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    busy         = (state_q != StIdle);
    done         = (state_q == StDone);
    illegal      = illegal_q;
    reg_sel      = sel_q;
    reg_rd_en    = (state_q == StRead);
    reg_wr_en    = (state_q == StWrite);
    ide_m        = m_q;
    ide_field    = field_q;
    ide_in       = 31'd0;
    reg_wdata    = 31'd0;
    overflow_set = 1'b0;
    if ((state_q == StExec) && !field_q[1]) begin
      ide_in = reg_rdata;
    end
    if (state_q == StWrite) begin
      if (is_index) begin
        reg_wdata    = {result_q[30], 18'd0, result_q[11:0]};
        overflow_set = |result_q[29:12];
      end else begin
        reg_wdata    = result_q;
        overflow_set = ovf_q;
      end
    end
  end

endmodule

// File: tb/tb_ide_seq.sv
// Scoreboard bench for ide_seq: stimulus pushes expected strobe events
// (read/write/done/illegal with their cycle), a negedge monitor pops and compares.
module tb_ide_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  c = 6'd0;
  logic [5:0]  f = 6'd0;
  logic [12:0] m = 13'd0;
  logic        busy, done, illegal, overflow_set;
  logic [2:0]  reg_sel;
  logic        reg_rd_en, reg_wr_en;
  logic [30:0] reg_rdata = 31'd0;
  logic [30:0] reg_wdata, ide_in, ide_out;
  logic [12:0] ide_m;
  logic [1:0]  ide_field;
  logic        ide_overflow;

  ide_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .c(c), .f(f), .m(m),
    .busy(busy), .done(done), .illegal(illegal), .overflow_set(overflow_set),
    .reg_sel(reg_sel), .reg_rd_en(reg_rd_en), .reg_rdata(reg_rdata),
    .reg_wr_en(reg_wr_en), .reg_wdata(reg_wdata), .ide_in(ide_in), .ide_m(ide_m),
    .ide_field(ide_field), .ide_out(ide_out), .ide_overflow(ide_overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file model: read data appears the cycle after the strobe.
  logic [30:0] regs [8];
  always @(posedge clk) begin
    if (reg_rd_en) reg_rdata <= regs[reg_sel];
  end

  // Sign-magnitude address-transfer datapath model.
  function automatic logic [31:0] dp(input logic [30:0] in, input logic [12:0] mm,
                                     input logic [1:0] fld);
    longint a, b, r, mag;
    logic s;
    logic [63:0] mu;
    a = in[30] ? -longint'(in[29:0]) : longint'(in[29:0]);
    b = mm[12] ? -longint'(mm[11:0]) : longint'(mm[11:0]);
    case (fld)
      2'd0: begin r = a + b; s = in[30]; end
      2'd1: begin r = a - b; s = in[30]; end
      2'd2: begin r = b; s = mm[12]; end
      default: begin r = -b; s = ~mm[12]; end
    endcase
    if (r < 0) s = 1'b1;
    else if (r > 0) s = 1'b0;
    mag = (r < 0) ? -r : r;
    mu = mag;
    return {(mag > longint'(30'h3FFF_FFFF)), s, mu[29:0]};
  endfunction

  always_comb begin
    {ide_overflow, ide_out} = dp(ide_in, ide_m, ide_field);
  end

  typedef struct {
    int          kind;  // 0 read, 1 write, 2 done, 3 illegal
    int          at;
    logic [2:0]  sel;
    logic [30:0] wdata;
    logic        ovf;
  } ev_t;
  ev_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int at, input logic [2:0] sel,
                      input logic [30:0] wdata, input logic ovf);
    ev_t e;
    e.kind = kind; e.at = at; e.sel = sel; e.wdata = wdata; e.ovf = ovf;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event", kind, -1);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.at);
      if (kind == 1) begin
        chk("wr_sel", reg_sel, e.sel);
        chk("wr_data", reg_wdata, e.wdata);
        chk("wr_ovf_set", overflow_set, e.ovf);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_rd_en) observe(0);
      if (reg_wr_en) observe(1);
      if (done) observe(2);
      if (illegal) observe(3);
      if (overflow_set && !reg_wr_en) chk("ovf_without_write", 1, 0);
    end
  end

  // Issue one command; rd says whether a read is expected, lat is the done cycle.
  task automatic cmd(input logic [5:0] cc, input logic [5:0] ff, input logic [12:0] mm,
                     input bit rd, input int lat, input logic [2:0] sel,
                     input logic [30:0] wdata, input logic ovf, output int t0);
    @(negedge clk);
    t0 = cyc;
    if (rd) push(0, t0 + 1, 3'd0, 31'd0, 1'b0);
    push(1, t0 + lat - 1, sel, wdata, ovf);
    push(2, t0 + lat, 3'd0, 31'd0, 1'b0);
    start = 1'b1; c = cc; f = ff; m = mm;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    for (int i = 0; i < 8; i++) regs[i] = 31'd0;
    regs[1] = 31'd3;
    regs[2] = 31'd4095;
    regs[7] = {1'b1, 30'h3FFF_FFFF};

    repeat (2) @(negedge clk);
    chk("reset_outputs", {busy, done, illegal, overflow_set, reg_sel, reg_rd_en, reg_wr_en,
                          reg_wdata, ide_in, ide_m, ide_field}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Scenario 1: INC I1 (+3) by +5.
    cmd(6'd49, 6'd0, 13'd5, 1'b1, 4, 3'd1, 31'd8, 1'b0, t0);
    chk("s1_busy", busy, 1);
    @(negedge clk);
    chk("s1_ide_in", ide_in, 3);
    chk("s1_ide_m", ide_m, 5);
    repeat (3) @(negedge clk);
    chk("s1_idle", busy, 0);

    // Scenario 2: ENN A with +100 -> -100, no read.
    cmd(6'd48, 6'd3, 13'd100, 1'b0, 3, 3'd0, 31'h4000_0064, 1'b0, t0);
    chk("s2_ide_in", ide_in, 0);
    chk("s2_field", ide_field, 3);
    repeat (3) @(negedge clk);

    // Scenario 3: INC I2 (+4095) by +1 -> +4096 truncates to +0, overflow.
    cmd(6'd50, 6'd0, 13'd1, 1'b1, 4, 3'd2, 31'd0, 1'b1, t0);
    repeat (4) @(negedge clk);

    // Scenario 4: DEC X (-(2^30-1)) by +1 -> datapath overflow.
    cmd(6'd55, 6'd1, 13'd1, 1'b1, 4, 3'd7, 31'h4000_0000, 1'b1, t0);
    chk("s4_sel", reg_sel, 7);
    repeat (4) @(negedge clk);

    // ENT I3 with -0: sign of zero is preserved.
    cmd(6'd51, 6'd2, 13'h1000, 1'b0, 3, 3'd3, 31'h4000_0000, 1'b0, t0);
    repeat (3) @(negedge clk);

    // Scenario 5: illegal opcode, then illegal field.
    @(negedge clk);
    push(3, cyc + 1, 3'd0, 31'd0, 1'b0);
    start = 1'b1; c = 6'd56; f = 6'd0; m = 13'd0;
    @(negedge clk);
    start = 1'b0;
    chk("s5a_busy", busy, 0);
    @(negedge clk);
    push(3, cyc + 1, 3'd0, 31'd0, 1'b0);
    start = 1'b1; c = 6'd48; f = 6'd4;
    @(negedge clk);
    start = 1'b0;
    chk("s5b_busy", busy, 0);
    repeat (2) @(negedge clk);

    // Scenario 6: start while busy, then reset during EXEC.
    @(negedge clk);
    push(0, cyc + 1, 3'd0, 31'd0, 1'b0);
    start = 1'b1; c = 6'd49; f = 6'd0; m = 13'd5;
    @(negedge clk);
    c = 6'd52; f = 6'd2;  // start held high while busy in READ
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("s6_reset_outputs", {busy, done, illegal, overflow_set, reg_sel, reg_rd_en, reg_wr_en,
                             reg_wdata, ide_in, ide_m, ide_field}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("s6_idle", busy, 0);
    chk("s6_sel", reg_sel, 0);

    chk("pending_events", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
